// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window MAC.
// ACC_WIDTH is sized for CONV_DW-bit operands; the datapath supports DATA_WIDTH up to CONV_DW.
package conv_pkg;

  localparam int CONV_DW    = 32;
  localparam int ACC_WIDTH  = 2 * CONV_DW + 5;
  localparam int PIPE_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clamp a wide signed value into the signed range of a dw-bit result.
  function automatic logic signed [ACC_WIDTH-1:0] saturate(
    input logic signed [ACC_WIDTH-1:0] x,
    input int                          dw
  );
    logic signed [ACC_WIDTH-1:0] mx;
    logic signed [ACC_WIDTH-1:0] mn;
    mx = $signed((ACC_WIDTH'(1) << (dw - 1)) - ACC_WIDTH'(1));
    mn = ~mx;
    if (x > mx)      return mx;
    else if (x < mn) return mn;
    return x;
  endfunction

endpackage

// File: rtl/conv_row_mac.sv
// One window row: masked element-wise multiplies (S1) and their row sum (S2).
module conv_row_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_KERNEL_SIZE = 5,
  parameter int ROW             = 0
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic [2:0]                                  ker_i,
  input  logic [MAX_KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  win_row_i,
  input  logic [MAX_KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  wt_row_i,
  output logic signed [ACC_WIDTH-1:0]                 row_sum_o
);

  localparam logic [2:0] ROW_IDX = 3'(ROW);

  logic signed [2*DATA_WIDTH-1:0] prod_d [MAX_KERNEL_SIZE];
  logic signed [2*DATA_WIDTH-1:0] prod_q [MAX_KERNEL_SIZE];
  logic signed [ACC_WIDTH-1:0]    sum_d;
  logic signed [ACC_WIDTH-1:0]    sum_q;

  // Products outside the active KxK area are forced to zero.
  always_comb begin
    for (int c = 0; c < MAX_KERNEL_SIZE; c++) begin
      prod_d[c] = '0;
      if ((ROW_IDX < ker_i) && (3'(c) < ker_i)) begin
        prod_d[c] = (2*DATA_WIDTH)'($signed(win_row_i[c])) *
                    (2*DATA_WIDTH)'($signed(wt_row_i[c]));
      end
    end
  end

  // S1: register masked products.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < MAX_KERNEL_SIZE; c++) prod_q[c] <= '0;
    end else begin
      for (int c = 0; c < MAX_KERNEL_SIZE; c++) prod_q[c] <= prod_d[c];
    end
  end

  // Sign-extended sum of the registered products.
  always_comb begin
    sum_d = '0;
    for (int c = 0; c < MAX_KERNEL_SIZE; c++) begin
      sum_d = sum_d + ACC_WIDTH'(prod_q[c]);
    end
  end

  // S2: register the row sum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign row_sum_o = sum_q;

endmodule

// File: rtl/conv_window_mac.sv
// Convolution window MAC: KxK window times stored kernel, plus bias, shifted,
// saturated and written to consecutive output addresses.
// Optional feature macro: CONV_WINDOW_MAC_RELU_EN (negative results written as 0).
//
// Window input has no ready: win_valid is taken as a transfer only while the
// FSM is in RUN, one window per cycle; in any other state it is ignored.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 12,
  parameter int MAX_KERNEL_SIZE = 5,
  parameter int SHIFT           = 0
) (
  input  logic                                                      clk,
  input  logic                                                      rstn,
  input  logic                                                      start,
  input  logic [2:0]                                                ker_size,
  input  logic [ADDR_WIDTH-1:0]                                     out_base_addr,
  input  logic                                                      wt_we,
  input  logic [2:0]                                                wt_row,
  input  logic [2:0]                                                wt_col,
  input  logic signed [DATA_WIDTH-1:0]                              wt_data,
  input  logic signed [DATA_WIDTH-1:0]                              bias,
  input  logic [MAX_KERNEL_SIZE-1:0][MAX_KERNEL_SIZE-1:0][DATA_WIDTH-1:0] win_data,
  input  logic                                                      win_valid,
  input  logic                                                      frame_done_in,
  output logic                                                      out_we,
  output logic [ADDR_WIDTH-1:0]                                     out_addr,
  output logic signed [DATA_WIDTH-1:0]                              out_data,
  output logic [ADDR_WIDTH-1:0]                                     out_count,
  output logic                                                      busy,
  output logic                                                      done,
  output state_t                                                    dbg_state
);

  localparam logic [2:0] MK3 = 3'(MAX_KERNEL_SIZE);

  state_t                      state_q, state_d;
  logic [1:0]                  drain_q, drain_d;
  logic [2:0]                  ker_q;
  logic [ADDR_WIDTH-1:0]       base_q;
  logic signed [DATA_WIDTH-1:0] bias_q;
  logic [MAX_KERNEL_SIZE-1:0][MAX_KERNEL_SIZE-1:0][DATA_WIDTH-1:0] wt_q;
  logic                        v1_q, v2_q, v3_q;
  logic signed [ACC_WIDTH-1:0] row_sum [MAX_KERNEL_SIZE];
  logic signed [ACC_WIDTH-1:0] total_d, total_q, shifted, sat;
  logic [DATA_WIDTH-1:0]       res;
  logic                        out_we_q;
  logic [ADDR_WIDTH-1:0]       out_addr_q, count_q;
  logic [DATA_WIDTH-1:0]       out_data_q;
  logic                        start_ok, accept;

  assign start_ok = (state_q == IDLE) && start && (ker_size != 3'd0);
  assign accept   = (state_q == RUN) && win_valid;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // FSM next state: DRAIN holds for the pipeline depth, then DONE for one cycle.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE:  if (start_ok) state_d = RUN;
      RUN: begin
        if (frame_done_in) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(PIPE_DEPTH - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame configuration captured on an accepted start; oversize K clamps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ker_q  <= '0;
      base_q <= '0;
      bias_q <= '0;
    end else if (start_ok) begin
      ker_q  <= (ker_size > MK3) ? MK3 : ker_size;
      base_q <= out_base_addr;
      bias_q <= bias;
    end
  end

  // Weight store: writable only while idle and only inside the array.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wt_q <= '0;
    end else if ((state_q == IDLE) && wt_we && (wt_row < MK3) && (wt_col < MK3)) begin
      wt_q[wt_row][wt_col] <= wt_data;
    end
  end

  for (genvar r = 0; r < MAX_KERNEL_SIZE; r++) begin : g_row
    conv_row_mac #(
      .DATA_WIDTH     (DATA_WIDTH),
      .MAX_KERNEL_SIZE(MAX_KERNEL_SIZE),
      .ROW            (r)
    ) u_row (
      .clk      (clk),
      .rstn     (rstn),
      .ker_i    (ker_q),
      .win_row_i(win_data[r]),
      .wt_row_i (wt_q[r]),
      .row_sum_o(row_sum[r])
    );
  end

  // Valid bits travelling alongside S1..S3.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= accept;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // Total of all row sums plus sign-extended bias.
  always_comb begin
    total_d = ACC_WIDTH'(bias_q);
    for (int r = 0; r < MAX_KERNEL_SIZE; r++) total_d = total_d + row_sum[r];
  end

  // S3: register the total.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) total_q <= '0;
    else       total_q <= total_d;
  end

  // Shift, saturate and optional ReLU feeding the output register.
  always_comb begin
    shifted = total_q >>> SHIFT;
    sat     = saturate(shifted, DATA_WIDTH);
    res     = sat[DATA_WIDTH-1:0];
`ifdef CONV_WINDOW_MAC_RELU_EN
    if (sat[ACC_WIDTH-1]) res = '0;
`endif
  end

  // S4: output write port and per-frame result counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      count_q    <= '0;
    end else begin
      out_we_q <= v3_q;
      if (v3_q) begin
        out_addr_q <= base_q + count_q;
        out_data_q <= res;
        count_q    <= count_q + 1'b1;
      end
      if (start_ok) count_q <= '0;
    end
  end

  assign out_we    = out_we_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_count = count_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Self-checking bench for conv_window_mac with a plain-arithmetic reference model.
module tb_conv_window_mac;
  import conv_pkg::*;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int MK = 5;
  localparam int SH = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic                           start = 1'b0;
  logic [2:0]                     ker_size = '0;
  logic [AW-1:0]                  out_base_addr = '0;
  logic                           wt_we = 1'b0;
  logic [2:0]                     wt_row = '0, wt_col = '0;
  logic signed [DW-1:0]           wt_data = '0;
  logic signed [DW-1:0]           bias = '0;
  logic [MK-1:0][MK-1:0][DW-1:0]  win_data = '0;
  logic                           win_valid = 1'b0;
  logic                           frame_done_in = 1'b0;
  logic                           out_we;
  logic [AW-1:0]                  out_addr;
  logic signed [DW-1:0]           out_data;
  logic [AW-1:0]                  out_count;
  logic                           busy, done;
  state_t                         dbg_state;

  conv_window_mac #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_KERNEL_SIZE(MK), .SHIFT(SH)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .ker_size(ker_size),
    .out_base_addr(out_base_addr), .wt_we(wt_we), .wt_row(wt_row), .wt_col(wt_col),
    .wt_data(wt_data), .bias(bias), .win_data(win_data), .win_valid(win_valid),
    .frame_done_in(frame_done_in), .out_we(out_we), .out_addr(out_addr),
    .out_data(out_data), .out_count(out_count), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] got_q[$];
  int               got_cyc_q[$];
  int   done_cyc = 0;
  int   done_cnt = 0;
  logic busy_at_done = 1'b0;

  // reference model state
  int m_wt[MK][MK];
  int cur_win[MK][MK];
  int m_k = 0, m_base = 0, m_bias = 0, m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output write and done pulse.
  always @(negedge clk) begin
    if (out_we) begin
      got_q.push_back({out_addr, out_data});
      got_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cyc     <= cyc;
      done_cnt     <= done_cnt + 1;
      busy_at_done <= busy;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] model_result();
    logic signed [127:0] acc;
    logic [DW-1:0] r;
    acc = 0;
    for (int i = 0; i < m_k; i++)
      for (int j = 0; j < m_k; j++)
        acc = acc + (longint'(m_wt[i][j]) * longint'(cur_win[i][j]));
    acc = acc + m_bias;
    acc = acc >>> SH;
    if (acc > 128'sh7FFFFFFF)        r = 32'h7FFFFFFF;
    else if (acc < -128'sh80000000)  r = 32'h80000000;
    else                             r = acc[DW-1:0];
`ifdef CONV_WINDOW_MAC_RELU_EN
    if (r[DW-1]) r = '0;
`endif
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    start = 0; wt_we = 0; win_valid = 0; frame_done_in = 0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < MK; i++) for (int j = 0; j < MK; j++) m_wt[i][j] = 0;
    clear_sb();
  endtask

  task automatic write_wt(input int r, input int c, input int d);
    wt_we = 1'b1; wt_row = 3'(r); wt_col = 3'(c); wt_data = d;
    tick();
    wt_we = 1'b0;
    if (r < MK && c < MK) m_wt[r][c] = d;
  endtask

  task automatic start_frame(input int k, input int base, input int b);
    start = 1'b1; ker_size = 3'(k); out_base_addr = AW'(base); bias = b;
    tick();
    start = 1'b0;
    if (k != 0) begin
      m_k = (k > MK) ? MK : k;
      m_base = base; m_bias = b; m_cnt = 0;
    end
  endtask

  task automatic send_window(input bit last);
    for (int i = 0; i < MK; i++) for (int j = 0; j < MK; j++) win_data[i][j] = cur_win[i][j];
    win_valid = 1'b1;
    frame_done_in = last;
    exp_q.push_back({AW'(m_base + m_cnt), model_result()});
    m_cnt++;
    tick();
    win_valid = 1'b0;
    frame_done_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c0;
    int n;
    c0 = done_cnt;
    n = 0;
    while (done_cnt == c0 && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (done_cnt == c0) begin
      n_errors++;
      $display("FAIL done_timeout got no done within %0d cycles", budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (out_we !== 1'b0)  begin n_errors++; $display("FAIL rst_out_we got %0b exp 0", out_we); end
    n_checks++; if (busy !== 1'b0)    begin n_errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    n_checks++; if (done !== 1'b0)    begin n_errors++; $display("FAIL rst_done got %0b exp 0", done); end
    n_checks++; if (out_addr !== '0)  begin n_errors++; $display("FAIL rst_out_addr got %0h exp 0", out_addr); end
    n_checks++; if (out_data !== '0)  begin n_errors++; $display("FAIL rst_out_data got %0h exp 0", out_data); end
    n_checks++; if (out_count !== '0) begin n_errors++; $display("FAIL rst_out_count got %0h exp 0", out_count); end
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_basic();
    int sent;
    clear_sb();
    for (int i = 0; i < MK; i++) for (int j = 0; j < MK; j++) write_wt(i, j, 1);
    start_frame(3, 100, 0);
    for (int i = 0; i < MK; i++) for (int j = 0; j < MK; j++) cur_win[i][j] = 8 * i + j;
    sent = cyc;
    send_window(1'b1);
    wait_done(40);
    n_checks++; if (got_q.size() != 1) begin n_errors++; $display("FAIL basic_nwrites got %0d exp 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if (got_q[0][DW-1:0] !== 32'd81) begin n_errors++; $display("FAIL basic_data got %0d exp 81", got_q[0][DW-1:0]); end
      n_checks++; if (got_q[0][AW+DW-1:DW] !== 12'd100) begin n_errors++; $display("FAIL basic_addr got %0d exp 100", got_q[0][AW+DW-1:DW]); end
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL basic_model got %0h exp %0h", got_q[0], exp_q[0]); end
      n_checks++; if (got_cyc_q[0] != sent + 4) begin n_errors++; $display("FAIL basic_latency got %0d exp %0d", got_cyc_q[0] - sent, 4); end
      n_checks++; if (done_cyc != got_cyc_q[0] + 1) begin n_errors++; $display("FAIL basic_done_cycle got %0d exp %0d", done_cyc, got_cyc_q[0] + 1); end
    end
    n_checks++; if (busy_at_done !== 1'b0) begin n_errors++; $display("FAIL basic_busy_at_done got %0b exp 0", busy_at_done); end
    n_checks++; if (out_count !== 12'd1) begin n_errors++; $display("FAIL basic_count got %0d exp 1", out_count); end
  endtask

  task automatic test_mask();
    clear_sb();
    for (int i = 0; i < MK; i++)
      for (int j = 0; j < MK; j++)
        if (i >= 2 || j >= 2) write_wt(i, j, 5);
    start_frame(2, 200, 0);
    for (int i = 0; i < MK; i++) for (int j = 0; j < MK; j++) cur_win[i][j] = 7;
    send_window(1'b1);
    wait_done(40);
    n_checks++; if (got_q.size() != 1) begin n_errors++; $display("FAIL mask_nwrites got %0d exp 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if (got_q[0][DW-1:0] !== 32'd28) begin n_errors++; $display("FAIL mask_data got %0d exp 28", got_q[0][DW-1:0]); end
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL mask_model got %0h exp %0h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_saturate();
    logic [DW-1:0] neg_exp;
`ifdef CONV_WINDOW_MAC_RELU_EN
    neg_exp = 32'h0;
`else
    neg_exp = 32'h80000000;
`endif
    clear_sb();
    for (int i = 0; i < MK; i++) for (int j = 0; j < MK; j++) write_wt(i, j, 32'h7FFFFFFF);
    start_frame(5, 300, 0);
    for (int i = 0; i < MK; i++) for (int j = 0; j < MK; j++) cur_win[i][j] = 32'h7FFFFFFF;
    send_window(1'b0);
    for (int i = 0; i < MK; i++) for (int j = 0; j < MK; j++) cur_win[i][j] = 32'h80000000;
    send_window(1'b1);
    wait_done(40);
    n_checks++; if (got_q.size() != 2) begin n_errors++; $display("FAIL sat_nwrites got %0d exp 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_checks++; if (got_q[0][DW-1:0] !== 32'h7FFFFFFF) begin n_errors++; $display("FAIL sat_pos got %0h exp 7fffffff", got_q[0][DW-1:0]); end
      n_checks++; if (got_q[1][DW-1:0] !== neg_exp) begin n_errors++; $display("FAIL sat_neg got %0h exp %0h", got_q[1][DW-1:0], neg_exp); end
      n_checks++; if (got_q[1][AW+DW-1:DW] !== 12'd301) begin n_errors++; $display("FAIL sat_addr got %0d exp 301", got_q[1][AW+DW-1:DW]); end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    clear_sb();
    // start with K=0 must be ignored
    start_frame(0, 5, 0);
    n_checks++; if (busy !== 1'b0 || dbg_state !== IDLE) begin n_errors++; $display("FAIL k0_ignored got busy %0b state %0d exp 0 0", busy, dbg_state); end
    for (int i = 0; i < MK; i++)
      for (int j = 0; j < MK; j++)
        write_wt(i, j, int'($urandom_range(0, 2000)) - 1000);
    base = 4093;
    start_frame(int'($urandom_range(2, 7)), base, int'($urandom_range(0, 200)) - 100);
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < MK; i++)
        for (int j = 0; j < MK; j++)
          cur_win[i][j] = int'($urandom_range(0, 2000)) - 1000;
      send_window(w == 5);
    end
    wait_done(40);
    n_checks++; if (got_q.size() != 6) begin n_errors++; $display("FAIL b2b_nwrites got %0d exp 6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL b2b_write%0d got %0h exp %0h", i, got_q[i], exp_q[i]); end
      n_checks++; if (got_q[i][AW+DW-1:DW] !== AW'(base + i)) begin n_errors++; $display("FAIL b2b_addr%0d got %0d exp %0d", i, got_q[i][AW+DW-1:DW], AW'(base + i)); end
      if (i > 0) begin
        n_checks++; if (got_cyc_q[i] != got_cyc_q[i-1] + 1) begin n_errors++; $display("FAIL b2b_gap%0d got %0d exp 1", i, got_cyc_q[i] - got_cyc_q[i-1]); end
      end
    end
    if (got_cyc_q.size() == 6) begin
      n_checks++; if (done_cyc != got_cyc_q[5] + 1) begin n_errors++; $display("FAIL b2b_done_cycle got %0d exp %0d", done_cyc, got_cyc_q[5] + 1); end
    end
    n_checks++; if (out_count !== 12'd6) begin n_errors++; $display("FAIL b2b_count got %0d exp 6", out_count); end
    n_checks++; if (busy_at_done !== 1'b0) begin n_errors++; $display("FAIL b2b_busy_at_done got %0b exp 0", busy_at_done); end
  endtask

  task automatic test_run_drop();
    clear_sb();
    write_wt(5, 0, 77);  // out of range, dropped
    start_frame(3, 50, 7);
    // weight write while running: dropped (model untouched)
    wt_we = 1'b1; wt_row = 3'd0; wt_col = 3'd0; wt_data = 12345;
    tick();
    wt_we = 1'b0;
    // start while running: ignored
    start = 1'b1; ker_size = 3'd5; out_base_addr = 12'd999; bias = 1000;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL drop_busy got %0b exp 1", busy); end
    for (int i = 0; i < MK; i++)
      for (int j = 0; j < MK; j++)
        cur_win[i][j] = int'($urandom_range(0, 200)) - 100;
    send_window(1'b1);
    wait_done(40);
    n_checks++; if (got_q.size() != 1) begin n_errors++; $display("FAIL drop_nwrites got %0d exp 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL drop_write got %0h exp %0h", got_q[0], exp_q[0]); end
    end
    // window in IDLE: ignored
    clear_sb();
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    repeat (8) tick();
    n_checks++; if (got_q.size() != 0) begin n_errors++; $display("FAIL idle_window got %0d writes exp 0", got_q.size()); end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    start_frame(4, 10, 0);
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < MK; i++)
        for (int j = 0; j < MK; j++)
          cur_win[i][j] = int'($urandom_range(0, 50));
      send_window(1'b0);
    end
    n_checks++; if (out_we !== 1'b1 || busy !== 1'b1) begin n_errors++; $display("FAIL mid_pre got we %0b busy %0b exp 1 1", out_we, busy); end
    rstn = 1'b0;
    #1;
    n_checks++; if (out_we !== 1'b0)   begin n_errors++; $display("FAIL mid_out_we got %0b exp 0", out_we); end
    n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL mid_busy got %0b exp 0", busy); end
    n_checks++; if (out_count !== '0)  begin n_errors++; $display("FAIL mid_count got %0d exp 0", out_count); end
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL mid_state got %0d exp 0", dbg_state); end
    clear_sb();
    for (int i = 0; i < MK; i++) for (int j = 0; j < MK; j++) m_wt[i][j] = 0;
    repeat (3) tick();
    rstn = 1'b1;
    repeat (10) tick();
    n_checks++; if (got_q.size() != 0) begin n_errors++; $display("FAIL mid_late_writes got %0d exp 0", got_q.size()); end
    // weights cleared by reset: result is bias only
    start_frame(3, 20, 5);
    for (int i = 0; i < MK; i++)
      for (int j = 0; j < MK; j++)
        cur_win[i][j] = int'($urandom_range(1, 500));
    send_window(1'b1);
    wait_done(40);
    n_checks++; if (got_q.size() != 1) begin n_errors++; $display("FAIL mid_after_nwrites got %0d exp 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if (got_q[0][DW-1:0] !== 32'd5) begin n_errors++; $display("FAIL wt_cleared got %0d exp 5", got_q[0][DW-1:0]); end
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL mid_after_model got %0h exp %0h", got_q[0], exp_q[0]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_saturate();
    test_back_to_back();
    test_run_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
